// File: rtl/telemetry_sequencer_if.sv
// Telemetry frame stream between the sequencer and the downstream link.
// The master drives the frame and valid; the slave returns ready.
interface telemetry_sequencer_if #(
    parameter int W     = 8,
    parameter int SEQ_W = 8
) ();
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_x;
    logic [W-1:0]     out_y;
    logic [W-1:0]     out_z;
    logic [W:0]       out_vx;
    logic [W:0]       out_vy;
    logic [W:0]       out_vz;
    logic [SEQ_W-1:0] out_seq;
    logic             out_first;

    modport master (
        output out_valid,
        output out_x,
        output out_y,
        output out_z,
        output out_vx,
        output out_vy,
        output out_vz,
        output out_seq,
        output out_first,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_x,
        input  out_y,
        input  out_z,
        input  out_vx,
        input  out_vy,
        input  out_vz,
        input  out_seq,
        input  out_first,
        output out_ready
    );
endinterface

// File: rtl/telemetry_sequencer.sv
// Periodic X/Y/Z sampler: strobes the coordinate registers, captures them, derives
// per-axis velocity and offers one frame at a time on a valid/ready stream.
module telemetry_sequencer #(
    parameter int W     = 8,
    parameter int CNT_W = 16,
    parameter int SEQ_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic [CNT_W-1:0]      i_period,
    output logic                  o_coord_load,
    input  logic [W-1:0]          i_coord_x,
    input  logic [W-1:0]          i_coord_y,
    input  logic [W-1:0]          i_coord_z,
    telemetry_sequencer_if.master tlm,
    output logic [SEQ_W-1:0]      o_overrun_cnt,
    output logic                  o_busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_LOAD    = 3'd2,
        S_CAPTURE = 3'd3,
        S_SEND    = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_period_eff;
    logic             w_running;
    logic             w_tick;
    logic             w_handshake;
    logic             w_overrun;
    logic             w_to_idle;

    logic             w_coord_load;
    logic             w_out_valid;
    logic             w_busy;

    logic             r_first;
    logic [W-1:0]     r_prev_x;
    logic [W-1:0]     r_prev_y;
    logic [W-1:0]     r_prev_z;
    logic [W:0]       w_vx;
    logic [W:0]       w_vy;
    logic [W:0]       w_vz;

    logic [W-1:0]     r_out_x;
    logic [W-1:0]     r_out_y;
    logic [W-1:0]     r_out_z;
    logic [W:0]       r_out_vx;
    logic [W:0]       r_out_vy;
    logic [W:0]       r_out_vz;
    logic [SEQ_W-1:0] r_out_seq;
    logic             r_out_first;

    logic [SEQ_W-1:0] r_seq;
    logic [SEQ_W-1:0] r_overrun_cnt;

    // A programmed period of zero behaves exactly like a period of one.
    assign w_period_eff = (i_period == '0) ? CNT_W'(1) : i_period;
    assign w_running    = (r_state != S_IDLE);
    assign w_tick       = w_running && (r_cnt >= (w_period_eff - CNT_W'(1)));
    assign w_handshake  = (r_state == S_SEND) && tlm.out_ready;
    assign w_overrun    = w_tick && (r_state inside {S_LOAD, S_CAPTURE, S_SEND});
    assign w_to_idle    = w_running && (w_state_next == S_IDLE);

    assign w_vx = {1'b0, i_coord_x} - {1'b0, r_prev_x};
    assign w_vy = {1'b0, i_coord_y} - {1'b0, r_prev_y};
    assign w_vz = {1'b0, i_coord_z} - {1'b0, r_prev_z};

    // NOTE: reset is sampled on the clock edge, so it lives only inside always_ff @(posedge clk).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: default first; every path then assigns, so no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_en) w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (!i_en)       w_state_next = S_IDLE;
                else if (w_tick) w_state_next = S_LOAD;
            end
            S_LOAD:    w_state_next = S_CAPTURE;
            S_CAPTURE: w_state_next = S_SEND;
            S_SEND: begin
                if (tlm.out_ready) w_state_next = i_en ? S_WAIT : S_IDLE;
            end
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_coord_load = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            S_IDLE:  w_busy       = 1'b0;
            S_LOAD:  w_coord_load = 1'b1;
            S_SEND:  w_out_valid  = 1'b1;
            default: ;
        endcase
    end

    // The period counter free-runs across a frame so the sample cadence never slips.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!w_running || w_to_idle) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_first <= 1'b1;
        end else if (w_to_idle) begin
            r_first <= 1'b1;
        end else if (r_state == S_CAPTURE) begin
            r_first <= 1'b0;
        end
    end

    // Frame fields change only in CAPTURE, which keeps them stable through SEND.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_z     <= '0;
            r_out_vx    <= '0;
            r_out_vy    <= '0;
            r_out_vz    <= '0;
            r_out_seq   <= '0;
            r_out_first <= 1'b0;
            r_prev_x    <= '0;
            r_prev_y    <= '0;
            r_prev_z    <= '0;
        end else if (r_state == S_CAPTURE) begin
            r_out_x     <= i_coord_x;
            r_out_y     <= i_coord_y;
            r_out_z     <= i_coord_z;
            r_out_vx    <= r_first ? '0 : w_vx;
            r_out_vy    <= r_first ? '0 : w_vy;
            r_out_vz    <= r_first ? '0 : w_vz;
            r_out_seq   <= r_seq;
            r_out_first <= r_first;
            r_prev_x    <= i_coord_x;
            r_prev_y    <= i_coord_y;
            r_prev_z    <= i_coord_z;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seq <= '0;
        end else if (w_handshake) begin
            r_seq <= r_seq + SEQ_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overrun_cnt <= '0;
        end else if (w_overrun && (r_overrun_cnt != '1)) begin
            r_overrun_cnt <= r_overrun_cnt + SEQ_W'(1);
        end
    end

    assign o_coord_load  = w_coord_load;
    assign o_busy        = w_busy;
    assign o_overrun_cnt = r_overrun_cnt;

    assign tlm.out_valid = w_out_valid;
    assign tlm.out_x     = r_out_x;
    assign tlm.out_y     = r_out_y;
    assign tlm.out_z     = r_out_z;
    assign tlm.out_vx    = r_out_vx;
    assign tlm.out_vy    = r_out_vy;
    assign tlm.out_vz    = r_out_vz;
    assign tlm.out_seq   = r_out_seq;
    assign tlm.out_first = r_out_first;

endmodule

// File: tb/tb_telemetry_sequencer.sv
// Self-checking bench for telemetry_sequencer: directed scenarios plus randomized
// traffic, all compared against a frame-level behavioural model.
module tb_telemetry_sequencer;

    localparam int W     = 8;
    localparam int CNT_W = 16;
    localparam int SEQ_W = 8;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] z;
        logic [8:0] vx;
        logic [8:0] vy;
        logic [8:0] vz;
        logic [7:0] seq;
        logic       first;
    } frame_t;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        en     = 1'b0;
    logic [15:0] period = 16'd10;
    logic [7:0]  cx     = 8'd0;
    logic [7:0]  cy     = 8'd0;
    logic [7:0]  cz     = 8'd0;
    logic        coord_load;
    logic        busy;
    logic [7:0]  overrun_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [70:0] g_bad_dut;
    logic [70:0] g_bad_exp;

    telemetry_sequencer_if #(.W(W), .SEQ_W(SEQ_W)) tlm ();

    telemetry_sequencer #(.W(W), .CNT_W(CNT_W), .SEQ_W(SEQ_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_en         (en),
        .i_period     (period),
        .o_coord_load (coord_load),
        .i_coord_x    (cx),
        .i_coord_y    (cy),
        .i_coord_z    (cz),
        .tlm          (tlm),
        .o_overrun_cnt(overrun_cnt),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference model: a running flag, the period count, and the age of the frame in
    // flight (-1 none, 1 load cycle, 2 capture cycle, 3 presented downstream).
    bit     m_on;
    int     m_cnt;
    int     m_age;
    int     m_seq;
    int     m_ovr;
    bit     m_first;
    int     m_px, m_py, m_pz;
    frame_t m_fr;

    task automatic model_update();
        int p;
        bit tick;
        bit leave;
        p = (period == 16'd0) ? 1 : int'(period);
        if (!rst_n) begin
            m_on = 0; m_cnt = 0; m_age = -1; m_seq = 0; m_ovr = 0; m_first = 1;
            m_px = 0; m_py = 0; m_pz = 0; m_fr = '0;
            return;
        end
        tick = m_on && (m_cnt >= p - 1);
        if (!m_on) begin
            if (en) begin
                m_on  = 1;
                m_cnt = 0;
            end
            return;
        end
        if (tick && m_age >= 1) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
        leave = 0;
        if (m_age < 0) begin
            if (!en)       leave = 1;
            else if (tick) m_age = 1;
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (m_age == 2) begin
            m_fr.x     = cx;
            m_fr.y     = cy;
            m_fr.z     = cz;
            m_fr.vx    = m_first ? 9'd0 : 9'(int'(cx) - m_px);
            m_fr.vy    = m_first ? 9'd0 : 9'(int'(cy) - m_py);
            m_fr.vz    = m_first ? 9'd0 : 9'(int'(cz) - m_pz);
            m_fr.seq   = 8'(m_seq);
            m_fr.first = m_first;
            m_px = cx; m_py = cy; m_pz = cz;
            m_first = 0;
            m_age = 3;
        end else if (tlm.out_ready) begin
            m_seq = (m_seq + 1) % 256;
            m_age = -1;
            if (!en) leave = 1;
        end
        if (leave) begin
            m_on = 0; m_cnt = 0; m_first = 1;
        end else begin
            m_cnt = tick ? 0 : m_cnt + 1;
        end
    endtask

    function automatic frame_t dut_frame();
        return {tlm.out_x, tlm.out_y, tlm.out_z, tlm.out_vx, tlm.out_vy, tlm.out_vz,
                tlm.out_seq, tlm.out_first};
    endfunction

    function automatic logic [70:0] dut_vec();
        return {dut_frame(), tlm.out_valid, coord_load, busy, overrun_cnt};
    endfunction

    function automatic logic [70:0] exp_vec();
        return {m_fr, (m_age >= 3), (m_age == 1), m_on, 8'(m_ovr)};
    endfunction

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic run_cycles(input int n, output int bad);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (dut_vec() !== exp_vec()) begin
                bad++;
                g_bad_dut = dut_vec();
                g_bad_exp = exp_vec();
            end
        end
    endtask

    task automatic run_until_valid(input int budget, output bit found, output int bad,
                                   output int cycles);
        found = 0; bad = 0; cycles = 0;
        while (!found && cycles < budget) begin
            step();
            cycles++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                g_bad_dut = dut_vec();
                g_bad_exp = exp_vec();
            end
            if (tlm.out_valid) found = 1;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        en = 1'b1; period = 16'd10; tlm.out_ready = 1'b1;
        rst_n = 1'b0;
        step();
        step();
        n_checks++;
        if (tlm.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", tlm.out_valid); end
        n_checks++;
        if (coord_load !== 1'b0) begin n_errors++; $display("FAIL reset_load: got %b want 0", coord_load); end
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++;
        if (overrun_cnt !== 8'd0) begin n_errors++; $display("FAIL reset_ovr: got %0d want 0", overrun_cnt); end
        n_checks++;
        if (dut_frame() !== frame_t'(0)) begin n_errors++; $display("FAIL reset_frame: got %h want 0", dut_frame()); end
        en = 1'b0;
        rst_n = 1'b1;
        step();
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_idle_hold: busy got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int t, t_load, t_valid, loads, bad, cyc;
        bit found;
        frame_t want;
        period = 16'd10; cx = 8'd10; cy = 8'd20; cz = 8'd30; tlm.out_ready = 1'b1; en = 1'b1;
        t = 0; t_load = -1; t_valid = -1; loads = 0; bad = 0;
        while (t_valid < 0 && t < 40) begin
            step();
            t++;
            if (dut_vec() !== exp_vec()) begin bad++; g_bad_dut = dut_vec(); g_bad_exp = exp_vec(); end
            if (coord_load) begin loads++; t_load = t; end
            if (tlm.out_valid) t_valid = t;
        end
        n_checks++;
        if (t_valid < 0) begin n_errors++; $display("FAIL basic_timeout: no frame within %0d cycles", t); end
        n_checks++;
        if (loads !== 1) begin n_errors++; $display("FAIL basic_load_width: got %0d cycles want 1", loads); end
        n_checks++;
        if (t_valid - t_load !== 2) begin n_errors++; $display("FAIL basic_latency: load->valid got %0d want 2", t_valid - t_load); end
        want = '{x: 8'd10, y: 8'd20, z: 8'd30, vx: 9'd0, vy: 9'd0, vz: 9'd0, seq: 8'd0, first: 1'b1};
        n_checks++;
        if (dut_frame() !== want) begin n_errors++; $display("FAIL basic_frame1: got %h want %h", dut_frame(), want); end
        cx = 8'd15; cy = 8'd18; cz = 8'd30;
        run_until_valid(20, found, cyc, cyc);
        n_checks++;
        if (cyc !== 10) begin n_errors++; $display("FAIL basic_interval: got %0d want 10", cyc); end
        want = '{x: 8'd15, y: 8'd18, z: 8'd30, vx: 9'h005, vy: 9'h1FE, vz: 9'd0, seq: 8'd1, first: 1'b0};
        n_checks++;
        if (dut_frame() !== want) begin n_errors++; $display("FAIL basic_frame2: got %h want %h", dut_frame(), want); end
        n_checks++;
        if (bad !== 0) begin n_errors++; $display("FAIL basic_model: %0d cycles differ, dut=%h model=%h", bad, g_bad_dut, g_bad_exp); end
    endtask

    task automatic test_wrap();
        bit found;
        int bad, cyc;
        cx = 8'd0;
        run_until_valid(20, found, bad, cyc);
        cx = 8'd255;
        run_until_valid(20, found, bad, cyc);
        n_checks++;
        if (!found || tlm.out_vx !== 9'h0FF) begin n_errors++; $display("FAIL wrap_up: vx got %h want 0ff", tlm.out_vx); end
        cx = 8'd0;
        run_until_valid(20, found, bad, cyc);
        n_checks++;
        if (!found || tlm.out_vx !== 9'h101) begin n_errors++; $display("FAIL wrap_down: vx got %h want 101", tlm.out_vx); end
        n_checks++;
        if (bad !== 0) begin n_errors++; $display("FAIL wrap_model: dut=%h model=%h", g_bad_dut, g_bad_exp); end
    endtask

    task automatic test_backpressure();
        bit found;
        int bad, cyc, stab_bad, load_bad;
        frame_t snap;
        period = 16'd4; en = 1'b1; tlm.out_ready = 1'b0;
        apply_reset();
        run_until_valid(20, found, bad, cyc);
        n_checks++;
        if (!found) begin n_errors++; $display("FAIL bp_timeout: no frame within %0d cycles", cyc); end
        snap = dut_frame();
        stab_bad = 0; load_bad = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (dut_vec() !== exp_vec()) begin bad++; g_bad_dut = dut_vec(); g_bad_exp = exp_vec(); end
            if (dut_frame() !== snap || !tlm.out_valid) stab_bad++;
            if (coord_load) load_bad++;
        end
        n_checks++;
        if (stab_bad !== 0) begin n_errors++; $display("FAIL bp_stable: %0d cycles changed, want 0", stab_bad); end
        n_checks++;
        if (load_bad !== 0) begin n_errors++; $display("FAIL bp_no_load: %0d strobes, want 0", load_bad); end
        n_checks++;
        if (overrun_cnt !== 8'd4) begin n_errors++; $display("FAIL bp_overrun: got %0d want 4", overrun_cnt); end
        tlm.out_ready = 1'b1;
        run_until_valid(10, found, cyc, cyc);
        run_until_valid(10, found, cyc, cyc);
        n_checks++;
        if (!found || cyc !== 4) begin n_errors++; $display("FAIL bp_resume: interval got %0d want 4", cyc); end
        n_checks++;
        if (bad !== 0) begin n_errors++; $display("FAIL bp_model: dut=%h model=%h", g_bad_dut, g_bad_exp); end
        tlm.out_ready = 1'b0;
        run_cycles(1250, bad);
        n_checks++;
        if (overrun_cnt !== 8'd255) begin n_errors++; $display("FAIL bp_saturate: got %0d want 255", overrun_cnt); end
        n_checks++;
        if (bad !== 0) begin n_errors++; $display("FAIL bp_sat_model: dut=%h model=%h", g_bad_dut, g_bad_exp); end
    endtask

    task automatic test_en_drop_in_load();
        bit found;
        int bad, cyc, t;
        period = 16'd5; en = 1'b1; tlm.out_ready = 1'b1;
        apply_reset();
        t = 0;
        while (!coord_load && t < 20) begin step(); t++; end
        n_checks++;
        if (!coord_load) begin n_errors++; $display("FAIL endrop_timeout: no load strobe in %0d cycles", t); end
        en = 1'b0;
        run_until_valid(5, found, bad, cyc);
        n_checks++;
        if (!found) begin n_errors++; $display("FAIL endrop_frame: frame not delivered within %0d cycles", cyc); end
        step();
        n_checks++;
        if (busy !== 1'b0 || tlm.out_valid !== 1'b0) begin
            n_errors++; $display("FAIL endrop_idle: busy=%b valid=%b want 0 0", busy, tlm.out_valid);
        end
        run_cycles(10, cyc);
        bad += cyc;
        cx = 8'($urandom_range(1, 255)); cy = 8'($urandom); cz = 8'($urandom);
        en = 1'b1;
        run_until_valid(20, found, cyc, cyc);
        n_checks++;
        if (!found || tlm.out_first !== 1'b1) begin n_errors++; $display("FAIL endrop_first: got %b want 1", tlm.out_first); end
        n_checks++;
        if ({tlm.out_vx, tlm.out_vy, tlm.out_vz} !== 27'd0) begin
            n_errors++; $display("FAIL endrop_vel: got %h %h %h want 0 0 0", tlm.out_vx, tlm.out_vy, tlm.out_vz);
        end
        n_checks++;
        if (bad !== 0) begin n_errors++; $display("FAIL endrop_model: dut=%h model=%h", g_bad_dut, g_bad_exp); end
    endtask

    task automatic test_reset_in_send();
        bit found;
        int bad, cyc;
        period = 16'd3; en = 1'b1; tlm.out_ready = 1'b1;
        run_until_valid(20, found, bad, cyc);
        run_until_valid(20, found, cyc, cyc);
        tlm.out_ready = 1'b0;
        run_until_valid(20, found, cyc, cyc);
        n_checks++;
        if (!found) begin n_errors++; $display("FAIL rsend_timeout: no frame in SEND"); end
        rst_n = 1'b0;
        step();
        n_checks++;
        if (tlm.out_valid !== 1'b0 || busy !== 1'b0 || coord_load !== 1'b0) begin
            n_errors++; $display("FAIL rsend_ctrl: valid=%b busy=%b load=%b want 0 0 0", tlm.out_valid, busy, coord_load);
        end
        n_checks++;
        if (dut_frame() !== frame_t'(0) || overrun_cnt !== 8'd0) begin
            n_errors++; $display("FAIL rsend_data: frame=%h ovr=%0d want 0 0", dut_frame(), overrun_cnt);
        end
        rst_n = 1'b1; tlm.out_ready = 1'b1;
        run_until_valid(20, found, cyc, cyc);
        n_checks++;
        if (!found || tlm.out_seq !== 8'd0 || tlm.out_first !== 1'b1) begin
            n_errors++; $display("FAIL rsend_restart: seq=%0d first=%b want 0 1", tlm.out_seq, tlm.out_first);
        end
    endtask

    task automatic test_period_zero();
        bit found;
        int bad, bad_total, cyc, prev_ovr, seq_bad, ovr_bad;
        period = 16'd0; en = 1'b1; tlm.out_ready = 1'b1;
        apply_reset();
        prev_ovr = 0; bad_total = 0; seq_bad = 0; ovr_bad = 0;
        for (int i = 0; i < 260; i++) begin
            run_until_valid(8, found, bad, cyc);
            bad_total += bad;
            if (!found) begin
                n_checks++; n_errors++;
                $display("FAIL p0_timeout: frame %0d missing", i);
                break;
            end
            n_checks++;
            if (tlm.out_seq !== 8'(i)) begin
                n_errors++; seq_bad++;
                if (seq_bad < 4) $display("FAIL p0_seq: frame %0d got %0d want %0d", i, tlm.out_seq, 8'(i));
            end
            if (i > 0 && prev_ovr <= 252) begin
                n_checks++;
                if (int'(overrun_cnt) - prev_ovr !== 3) begin
                    n_errors++; ovr_bad++;
                    if (ovr_bad < 4) $display("FAIL p0_ovr_step: got +%0d want +3", int'(overrun_cnt) - prev_ovr);
                end
            end
            prev_ovr = int'(overrun_cnt);
        end
        n_checks++;
        if (bad_total !== 0) begin n_errors++; $display("FAIL p0_model: dut=%h model=%h", g_bad_dut, g_bad_exp); end
    endtask

    task automatic test_random();
        int bad;
        apply_reset();
        bad = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) period = 16'($urandom_range(0, 6));
            en            = ($urandom_range(0, 15) != 0);
            tlm.out_ready = ($urandom_range(0, 3) != 0);
            rst_n         = ($urandom_range(0, 499) != 0);
            cx = 8'($urandom); cy = 8'($urandom); cz = 8'($urandom);
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_errors++; bad++;
                if (bad < 5) $display("FAIL random_cycle %0d: dut=%h model=%h", i, dut_vec(), exp_vec());
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        tlm.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_en_drop_in_load();
        test_reset_in_send();
        test_period_zero();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/telemetry_sequencer.md
Name: telemetry_sequencer

Overview:
- Periodic sample controller for the X/Y/Z coordinate registers.
- Programmable period counter strobes coord_load to the three coordinate registers, then captures their outputs one cycle later.
- Computes per-axis signed velocity (current minus previous sample) and presents a telemetry frame on a valid/ready interface.
- Sits between the coordinate registers and the downstream telemetry link. Counts frames and dropped sample ticks.

Parameters:
W, 8, coordinate width per axis (unsigned)
CNT_W, 16, width of sample period counter
SEQ_W, 8, width of frame sequence number and overrun counter

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous reset, active-low
en  in  1  sampling enable
period  in  CNT_W  sample period in clk cycles; 0 treated as 1
coord_load  out  1  one-cycle load strobe to coordinate registers
coord_x  in  W  X coordinate register output
coord_y  in  W  Y coordinate register output
coord_z  in  W  Z coordinate register output
out_valid  out  1  frame valid
out_ready  in  1  downstream accepts frame
out_x, out_y, out_z  out  W each  captured coordinates
out_vx, out_vy, out_vz  out  W+1 each  signed two's-complement velocity
out_seq  out  SEQ_W  frame sequence number
out_first  out  1  first frame since enable; velocities forced 0
overrun_cnt  out  SEQ_W  dropped ticks, saturating
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE, counter 0, all outputs 0, prev coords 0, first flag 1, seq 0, overrun_cnt 0. Reset overrides everything, including mid-frame; a frame in SEND is discarded.
- States: IDLE, WAIT, LOAD, CAPTURE, SEND.
- IDLE: counter held 0. en=1 -> WAIT.
- Counter runs in WAIT/LOAD/CAPTURE/SEND. tick = (cnt >= max(period,1)-1). On tick cnt->0, else cnt+1. The >= compare makes a period reduction below the current count tick immediately.
- WAIT:
  - tick -> LOAD.
  - en=0 (checked before tick) -> IDLE, counter cleared, first flag set.
- LOAD: coord_load=1 for exactly this cycle -> CAPTURE.
- CAPTURE:
  - Register coord_* into out_x/y/z.
  - v = {1'b0,cur} - {1'b0,prev}, W+1 bits; if first flag, v=0.
  - out_first = first flag. prev <= cur. First flag cleared.
  - -> SEND.
- SEND:
  - out_valid=1. All out_* fields stable until handshake.
  - On out_valid & out_ready: seq increments (wraps 2^SEQ_W-1 -> 0). Next state WAIT if en=1, else IDLE with first flag set.
  - out_valid drops the cycle after the handshake.
- Latency: tick in cycle T -> coord_load at T+1 -> out_valid at T+3 at the earliest.
- Overrun: tick while in LOAD, CAPTURE or SEND is dropped. overrun_cnt increments, saturating at 2^SEQ_W-1. No frame is queued. The counter keeps running.
- en=0 in LOAD/CAPTURE/SEND: the current frame completes, then IDLE.
- Tick and handshake in the same SEND cycle: the tick counts as an overrun, then WAIT.
- out_seq shows the seq value at capture; the first frame after reset has seq 0.

Test Plan:
1. Reset, period=10, en=1, coords (10,20,30).
   - Required: coord_load 1 cycle; out_valid 3 cycles after tick.
   - Frame: x,y,z=10,20,30; v=0,0,0; out_first=1; seq=0.
   - Next sample coords (15,18,30): v=(+5,-2,0), out_first=0, seq=1, frame interval exactly 10 cycles.
2. Wrap arithmetic.
   - X 0 -> 255: out_vx=+255 (9'h0FF).
   - X 255 -> 0: out_vx=-255 (9'h101).
3. Backpressure, period=4, out_ready=0 for 20 cycles.
   - Required: one frame held stable throughout; overrun_cnt=4; no coord_load while stalled.
   - After out_ready=1: normal cadence resumes.
   - 300 stalled ticks: overrun_cnt saturates at 255.
4. en dropped in LOAD.
   - Required: frame still delivered, then IDLE, busy=0.
   - Re-enable: next frame has out_first=1 and v=0 regardless of coords.
5. Reset asserted while in SEND.
   - Required: next cycle out_valid=0, all outputs 0, IDLE.
   - Re-enable: first frame seq=0.
6. period=0.
   - Required: behaves as period=1; tick every cycle; overrun_cnt +3 per frame with out_ready=1.
   - 256 frames: seq wraps 255 -> 0.
